// File: rtl/dpram_arb_pkg.sv
// Shared constants and types for dpram_arbiter.
// The optional perf counters are enabled with DPRAM_ARB_PERF_EN.
package dpram_arb_pkg;

  localparam int unsigned DefAwidth = 10;
  localparam int unsigned DefDwidth = 16;
  localparam int unsigned DefNumReq = 4;
  localparam int unsigned PerfCntW  = 32;

  typedef logic [DefNumReq-1:0] req_onehot_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority first-one finder: returns the first set bit of req scanning
// cyclically upward from start, as one-hot and as an index.
module rr_pick #(
  parameter  int unsigned N    = 4,
  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [PtrW-1:0] start,
  output logic [N-1:0]    pick,
  output logic [PtrW-1:0] idx,
  output logic            found
);

  always_comb begin
    int unsigned j;
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(start) + k) % N;
      if (!found && req[j]) begin
        found   = 1'b1;
        idx     = PtrW'(j);
        pick[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dpram_arbiter.sv
// Round-robin arbiter mapping up to two requests per cycle onto a dual-port RAM,
// with same-address hazard suppression. Define DPRAM_ARB_PERF_EN for perf counters.
module dpram_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int unsigned AWIDTH  = DefAwidth,
  parameter int unsigned DWIDTH  = DefDwidth,
  parameter int unsigned NUM_REQ = DefNumReq
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*AWIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DWIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DWIDTH-1:0]         rsp_data,
  output logic [NUM_REQ-1:0]        rsp_valid_b,
  output logic [DWIDTH-1:0]         rsp_data_b,
  output logic [AWIDTH-1:0]         ram_address_a,
  output logic [AWIDTH-1:0]         ram_address_b,
  output logic                      ram_wren_a,
  output logic                      ram_wren_b,
  output logic [DWIDTH-1:0]         ram_data_a,
  output logic [DWIDTH-1:0]         ram_data_b,
  input  logic [DWIDTH-1:0]         ram_out_a,
  input  logic [DWIDTH-1:0]         ram_out_b
`ifdef DPRAM_ARB_PERF_EN
  ,
  output logic [PerfCntW-1:0]       perf_grant_cnt,
  output logic [PerfCntW-1:0]       perf_stall_cnt
`endif
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] valid_m, pick_a, pick_b, conflict, mask_b;
  logic [NUM_REQ-1:0] tag_a_q, tag_b_q, tag_a_d, tag_b_d;
  logic [PtrW-1:0]    idx_a, idx_b, rr_ptr_q, rr_ptr_d;
  logic               found_a, found_b, we_a, we_b;
  logic [AWIDTH-1:0]  addr_a, addr_b;
  logic [DWIDTH-1:0]  wdata_a, wdata_b;

  function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] i);
    return (32'(i) == NUM_REQ - 1) ? '0 : i + PtrW'(1);
  endfunction

  // Nothing is granted while reset is held.
  assign valid_m = req_valid & {NUM_REQ{resetn}};

  rr_pick #(.N(NUM_REQ)) u_pick_a (
    .req   (valid_m),
    .start (rr_ptr_q),
    .pick  (pick_a),
    .idx   (idx_a),
    .found (found_a)
  );

  always_comb begin
    addr_a  = req_addr[32'(idx_a)*AWIDTH +: AWIDTH];
    we_a    = req_we[idx_a];
    wdata_a = req_wdata[32'(idx_a)*DWIDTH +: DWIDTH];
    conflict = '0;
    // Same address conflicts unless both sides are reads.
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      conflict[i] = (req_addr[i*AWIDTH +: AWIDTH] == addr_a) && (req_we[i] || we_a);
    end
    mask_b = valid_m & ~pick_a & ~conflict;
  end

  rr_pick #(.N(NUM_REQ)) u_pick_b (
    .req   (mask_b),
    .start (rr_ptr_q),
    .pick  (pick_b),
    .idx   (idx_b),
    .found (found_b)
  );

  always_comb begin
    addr_b  = req_addr[32'(idx_b)*AWIDTH +: AWIDTH];
    we_b    = req_we[idx_b];
    wdata_b = req_wdata[32'(idx_b)*DWIDTH +: DWIDTH];
  end

  assign req_ready     = pick_a | pick_b;
  assign ram_wren_a    = found_a & we_a;
  assign ram_address_a = found_a ? addr_a : '0;
  assign ram_data_a    = found_a ? wdata_a : '0;
  assign ram_wren_b    = found_b & we_b;
  assign ram_address_b = found_b ? addr_b : '0;
  assign ram_data_b    = found_b ? wdata_b : '0;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    // Port B always lies after port A in scan order, so it is the last grant.
    if (found_b) begin
      rr_ptr_d = wrap_inc(idx_b);
    end else if (found_a) begin
      rr_ptr_d = wrap_inc(idx_a);
    end
    tag_a_d = (found_a && !we_a) ? pick_a : '0;
    tag_b_d = (found_b && !we_b) ? pick_b : '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr_q <= '0;
      tag_a_q  <= '0;
      tag_b_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      tag_a_q  <= tag_a_d;
      tag_b_q  <= tag_b_d;
    end
  end

  assign rsp_valid   = tag_a_q;
  assign rsp_data    = ram_out_a;
  assign rsp_valid_b = tag_b_q;
  assign rsp_data_b  = ram_out_b;

`ifdef DPRAM_ARB_PERF_EN
  logic [PerfCntW-1:0] grant_cnt_q, grant_cnt_d, stall_cnt_q, stall_cnt_d;
  logic [PerfCntW:0]   grant_sum;

  always_comb begin
    grant_sum   = {1'b0, grant_cnt_q} + (PerfCntW+1)'(found_a) + (PerfCntW+1)'(found_b);
    grant_cnt_d = grant_sum[PerfCntW] ? '1 : grant_sum[PerfCntW-1:0];
    stall_cnt_d = stall_cnt_q;
    if (|(valid_m & ~req_ready) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + PerfCntW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_grant_cnt = grant_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dpram_arbiter.sv
// Scoreboard bench for dpram_arbiter: directed scenarios then random traffic,
// checked against a request-level model and a behavioural dual-port RAM.
module tb_dpram_arbiter;
  import dpram_arb_pkg::*;

  localparam int unsigned N  = DefNumReq;
  localparam int unsigned AW = DefAwidth;
  localparam int unsigned DW = DefDwidth;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [N-1:0]    req_valid = '0, req_ready, req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    rsp_valid, rsp_valid_b;
  logic [DW-1:0]   rsp_data, rsp_data_b;
  logic [AW-1:0]   ram_address_a, ram_address_b;
  logic            ram_wren_a, ram_wren_b;
  logic [DW-1:0]   ram_data_a, ram_data_b, ram_out_a, ram_out_b;
`ifdef DPRAM_ARB_PERF_EN
  logic [PerfCntW-1:0] perf_grant_cnt, perf_stall_cnt;
`endif

  dpram_arbiter u_dut (
    .clk           (clk),
    .resetn        (resetn),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_valid_b   (rsp_valid_b),
    .rsp_data_b    (rsp_data_b),
    .ram_address_a (ram_address_a),
    .ram_address_b (ram_address_b),
    .ram_wren_a    (ram_wren_a),
    .ram_wren_b    (ram_wren_b),
    .ram_data_a    (ram_data_a),
    .ram_data_b    (ram_data_b),
    .ram_out_a     (ram_out_a),
    .ram_out_b     (ram_out_b)
`ifdef DPRAM_ARB_PERF_EN
    ,
    .perf_grant_cnt(perf_grant_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural RAM: registered read, one-cycle latency, cleared during reset.
  logic [DW-1:0] mem [1<<AW];
  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
    end else begin
      if (ram_wren_a) mem[ram_address_a] <= ram_data_a;
      if (ram_wren_b) mem[ram_address_b] <= ram_data_b;
    end
    ram_out_a <= mem[ram_address_a];
    ram_out_b <= mem[ram_address_b];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Requester state and reference model.
  logic [N-1:0]  v = '0, w = '0;
  logic [AW-1:0] a [N];
  logic [DW-1:0] d [N];
  logic [DW-1:0] shadow [1<<AW];
  int            m_ptr = 0;
  longint        m_gcnt = 0, m_scnt = 0;
  logic [N-1:0]  last_ready;

  typedef struct {
    int           cyc;
    logic [N-1:0] tag;
    logic [DW-1:0] data;
  } exp_t;
  exp_t q_a[$], q_b[$];

  task automatic drive();
    req_valid = v;
    req_we    = w;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = a[i];
      req_wdata[i*DW +: DW] = d[i];
    end
  endtask

  // Cyclic scan from the pointer: first valid to A, next non-conflicting valid to B.
  task automatic model_grant(output int ga, output int gb);
    ga = -1;
    gb = -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (v[i]) begin
        if (ga < 0) ga = i;
        else if (gb < 0 && !(a[i] == a[ga] && (w[i] || w[ga]))) gb = i;
      end
    end
  endtask

  task automatic check_port(input string name, input int g, input logic wren,
                            input logic [AW-1:0] addr, input logic [DW-1:0] data);
    if (g < 0) begin
      check({name, "_idle"}, 64'({wren, addr, data}), 64'(0));
    end else begin
      check({name, "_wren_addr"}, 64'({wren, addr}), 64'({w[g], a[g]}));
      if (w[g]) check({name, "_wdata"}, 64'(data), 64'(d[g]));
    end
  endtask

  task automatic step();
    int ga, gb;
    logic [N-1:0] er;
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
`ifdef DPRAM_ARB_PERF_EN
    check("perf_grant_cnt", 64'(perf_grant_cnt), 64'(m_gcnt));
    check("perf_stall_cnt", 64'(perf_stall_cnt), 64'(m_scnt));
`endif
    last_ready = req_ready;
    if (!resetn) begin
      check("ready_in_reset", 64'(req_ready), 64'(0));
      check("wren_in_reset", 64'({ram_wren_a, ram_wren_b}), 64'(0));
      return;
    end
    model_grant(ga, gb);
    er = '0;
    if (ga >= 0) er[ga] = 1'b1;
    if (gb >= 0) er[gb] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(er));
    check_port("ram_a", ga, ram_wren_a, ram_address_a, ram_data_a);
    check_port("ram_b", gb, ram_wren_b, ram_address_b, ram_data_b);
    if (ga >= 0 && !w[ga]) q_a.push_back('{cyc: cyc, tag: N'(1) << ga, data: shadow[a[ga]]});
    if (gb >= 0 && !w[gb]) q_b.push_back('{cyc: cyc, tag: N'(1) << gb, data: shadow[a[gb]]});
    if (ga >= 0 && w[ga]) shadow[a[ga]] = d[ga];
    if (gb >= 0 && w[gb]) shadow[a[gb]] = d[gb];
    m_gcnt += (ga >= 0 ? 1 : 0) + (gb >= 0 ? 1 : 0);
    if ((v & ~er) != '0) m_scnt++;
    if (gb >= 0) m_ptr = (gb + 1) % N;
    else if (ga >= 0) m_ptr = (ga + 1) % N;
    v = v & ~er;
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    q_a.delete();
    q_b.delete();
    m_ptr  = 0;
    m_gcnt = 0;
    m_scnt = 0;
    for (int i = 0; i < (1 << AW); i++) shadow[i] = '0;
    repeat (cycles) step();
    v = '0;
    drive();
    resetn = 1'b1;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data);
    v[i] = 1'b1;
    w[i] = we;
    a[i] = addr;
    d[i] = data;
  endtask

  // Monitor: one expected entry per response, popped when the DUT shows it or it is late.
  task automatic mon_lane(input string name, input bit lane_b, input logic [N-1:0] rv,
                          input logic [DW-1:0] rd);
    exp_t e;
    bit   have;
    have = lane_b ? (q_b.size() > 0) : (q_a.size() > 0);
    if (have) e = lane_b ? q_b[0] : q_a[0];
    if (!have) begin
      if (rv != '0) check({name, "_spurious"}, 64'(rv), 64'(0));
    end else if (rv != '0 || e.cyc + 1 <= cyc) begin
      if (lane_b) void'(q_b.pop_front());
      else void'(q_a.pop_front());
      check({name, "_tag"}, 64'(rv), 64'(e.tag));
      check({name, "_data"}, 64'(rd), 64'(e.data));
      check({name, "_latency"}, 64'(cyc), 64'(e.cyc + 1));
    end
  endtask

  always @(posedge clk) begin
    #3;
    mon_lane("rsp_a", 1'b0, rsp_valid, rsp_data);
    mon_lane("rsp_b", 1'b1, rsp_valid_b, rsp_data_b);
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      a[i] = '0;
      d[i] = '0;
    end
    // Pending writes during reset must not reach the RAM.
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i), DW'(16'hAAAA));
    do_reset(3);
    check("reset_rsp_valid", 64'({rsp_valid, rsp_valid_b}), 64'(0));

    // Write then read back on requester 0.
    set_req(0, 1'b1, 10'h005, 16'h0280);
    step();
    set_req(0, 1'b0, 10'h005, 16'h0000);
    step();
    check("t1_read_grant", 64'(last_ready), 64'(4'b0001));

    // Write and read to the same address in one cycle: only the write goes.
    set_req(1, 1'b1, 10'h00A, 16'hFF80);
    set_req(2, 1'b0, 10'h00A, 16'h0000);
    step();
    check("t2_first", 64'(last_ready), 64'(4'b0010));
    step();
    check("t2_second", 64'(last_ready), 64'(4'b0100));

    // Colliding writes from a fresh pointer: 0 first, 3 second.
    do_reset(2);
    set_req(0, 1'b1, 10'h030, 16'h0400);
    set_req(3, 1'b1, 10'h030, 16'h0500);
    step();
    check("t3_first", 64'(last_ready), 64'(4'b0001));
    step();
    check("t3_second", 64'(last_ready), 64'(4'b1000));
    set_req(1, 1'b0, 10'h030, 16'h0000);
    step();

    // Two writes to distinct addresses share one cycle, then dual readback.
    set_req(0, 1'b1, 10'h020, 16'h0100);
    set_req(1, 1'b1, 10'h021, 16'h0180);
    step();
    check("t4_write_pair", 64'(last_ready), 64'(4'b0011));
    set_req(0, 1'b0, 10'h020, 16'h0000);
    set_req(1, 1'b0, 10'h021, 16'h0000);
    step();
    check("t4_read_pair", 64'(last_ready), 64'(4'b0011));

    // Reset right after a read grant drops the response.
    set_req(2, 1'b0, 10'h020, 16'h0000);
    step();
    do_reset(2);

    // All requesters reading continuously rotate in pairs from requester 0.
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(10'h100 + i), 16'h0000);
      step();
      check("t5_rotation", 64'(last_ready), 64'((k % 2 == 0) ? 4'b0011 : 4'b1100));
    end
    step();
`ifdef DPRAM_ARB_PERF_EN
    check("t5_perf_grant", 64'(perf_grant_cnt), 64'(16));
    check("t5_perf_stall", 64'(perf_stall_cnt), 64'(8));
`endif

    // Random traffic over a small address window to provoke conflicts.
    repeat (1500) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] && $urandom_range(0, 3) != 0) begin
          set_req(i, ($urandom_range(0, 2) == 0), AW'($urandom_range(0, 7)), DW'($urandom));
        end
      end
      step();
    end

    v = '0;
    repeat (3) step();
    check("drain_a", 64'(q_a.size()), 64'(0));
    check("drain_b", 64'(q_b.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
